// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C master.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StBit,
    StAck,
    StStop,
    StDone
  } state_e;

  localparam int unsigned START_Q = 2;
  localparam int unsigned BIT_Q   = 4;
  localparam int unsigned STOP_Q  = 4;
  localparam int unsigned BYTES   = 3;

  // Index of the final quarter of a bus phase.
  function automatic logic [1:0] last_quarter(state_e s);
    case (s)
      StStart: return 2'(START_Q - 1);
      StStop:  return 2'(STOP_Q - 1);
      default: return 2'(BIT_Q - 1);
    endcase
  endfunction

endpackage

// File: rtl/i2c_qtimer.sv
// Quarter-period tick generator with SCL synchronizer and clock-stretch hold.
module i2c_qtimer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_run,
  input  logic                       i_qlast,
  input  logic                       i_scl_released,
  input  logic                       i_scl_sync_in,
  output logic                       o_tick,
  output logic [$clog2(BIT_Q)-1:0]   o_qidx
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned QW = $clog2(BIT_Q);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

  logic [1:0]    r_scl_sync;
  logic [1:0]    r_rel_dly;
  logic [CW-1:0] r_cnt;
  logic [QW-1:0] r_qidx;
  logic          w_stretch;
  logic          w_wrap;

  // Release is delayed by the synchronizer depth so our own release never reads as a stretch;
  // only cycles the slave keeps SCL low beyond our release are held.
  assign w_stretch = r_rel_dly[1] & ~r_scl_sync[1];
  assign w_wrap    = (r_cnt == LAST_CNT);
  assign o_tick    = i_run & ~w_stretch & w_wrap;
  assign o_qidx    = r_qidx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_sync <= 2'b11;
      r_rel_dly  <= 2'b11;
      r_cnt      <= '0;
      r_qidx     <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl_sync_in};
      r_rel_dly  <= {r_rel_dly[0], i_scl_released};
      if (!i_run) begin
        r_cnt  <= '0;
        r_qidx <= '0;
      end else if (!w_stretch) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_qidx <= i_qlast ? '0 : r_qidx + QW'(1);
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Write-only single-master I2C controller: START, device, register address, data, STOP.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        scl,
  inout  wire        sda,
  input  logic       valid,
  output logic       ready,
  input  logic [7:0] device,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       ack_err
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [23:0] r_shift;
  logic [23:0] w_shift_nxt;
  logic [3:0]  r_bit;
  logic [3:0]  w_bit_nxt;
  logic [1:0]  r_byte;
  logic [1:0]  w_byte_nxt;
  logic        r_err;
  logic        w_err_nxt;
  logic [1:0]  r_sda_sync;

  logic        w_tick;
  logic [1:0]  w_qidx;
  logic        w_qlast;
  logic        w_run;
  logic        w_scl_rel;
  logic        w_sda_rel;

  assign w_run   = (r_state != StIdle) && (r_state != StDone);
  assign w_qlast = (w_qidx == last_quarter(r_state));

  i2c_qtimer #(
    .CLK_DIV (CLK_DIV)
  ) u_qtimer (
    .clk            (clk),
    .reset          (reset),
    .i_run          (w_run),
    .i_qlast        (w_qlast),
    .i_scl_released (w_scl_rel),
    .i_scl_sync_in  (scl),
    .o_tick         (w_tick),
    .o_qidx         (w_qidx)
  );

  assign scl     = w_scl_rel ? 1'bz : 1'b0;
  assign sda     = w_sda_rel ? 1'bz : 1'b0;
  assign ready   = (r_state == StDone);
  assign ack_err = (r_state == StDone) & r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_err      <= 1'b0;
      r_sda_sync <= 2'b11;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit      <= w_bit_nxt;
      r_byte     <= w_byte_nxt;
      r_err      <= w_err_nxt;
      r_sda_sync <= {r_sda_sync[0], sda};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_err_nxt   = r_err;
    w_scl_rel   = 1'b1;
    w_sda_rel   = 1'b1;
    unique case (r_state)
      StIdle: begin
        if (valid) begin
          w_shift_nxt = {device, addr, data};
          w_bit_nxt   = '0;
          w_byte_nxt  = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = StStart;
        end
      end
      StStart: begin
        w_sda_rel = 1'b0;
        w_scl_rel = (w_qidx == 2'd0);
        if (w_tick && w_qlast) w_state_nxt = StBit;
      end
      StBit: begin
        w_scl_rel = w_qidx[1];
        w_sda_rel = r_shift[23];
        if (w_tick && w_qlast) begin
          w_shift_nxt = {r_shift[22:0], 1'b0};
          w_bit_nxt   = r_bit + 4'd1;
          if (r_bit == 4'd7) w_state_nxt = StAck;
        end
      end
      StAck: begin
        w_scl_rel = w_qidx[1];
        // SDA is sampled while SCL is high, at the tick closing the third quarter.
        if (w_tick && (w_qidx == 2'd2) && r_sda_sync[1]) w_err_nxt = 1'b1;
        if (w_tick && w_qlast) begin
          w_bit_nxt = '0;
          if (r_err || (r_byte == 2'(BYTES - 1))) begin
            w_state_nxt = StStop;
          end else begin
            w_byte_nxt  = r_byte + 2'd1;
            w_state_nxt = StBit;
          end
        end
      end
      StStop: begin
        w_scl_rel = (w_qidx != 2'd0);
        w_sda_rel = w_qidx[1];
        if (w_tick && w_qlast) w_state_nxt = StDone;
      end
      StDone: begin
        w_err_nxt   = 1'b0;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: byte-level slave model, latency/ready model, directed scenarios.
module tb_i2c_master;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] device;
  logic [7:0] addr;
  logic [7:0] data;
  logic       ready;
  logic       ack_err;
  wire        scl_bus;
  wire        sda_bus;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  i2c_master #(
    .CLK_DIV (D)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .scl     (scl_bus),
    .sda     (sda_bus),
    .valid   (valid),
    .ready   (ready),
    .device  (device),
    .addr    (addr),
    .data    (data),
    .ack_err (ack_err)
  );

  pullup (scl_bus);
  pullup (sda_bus);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------- slave / bus monitor ----------------
  logic sl_scl_low = 1'b0;
  logic sl_sda_low = 1'b0;
  assign scl_bus = sl_scl_low ? 1'b0 : 1'bz;
  assign sda_bus = sl_sda_low ? 1'b0 : 1'bz;

  bit slave_en   = 1'b1;
  bit stretch_en = 1'b0;
  bit gap_chk_en = 1'b0;
  int s_bytes[$];
  int sl_bitn = 0, sl_byten = 0, n_start = 0, n_stop = 0, n_edges = 0;
  int last_stop = 0;
  bit have_stop = 1'b0;

  initial begin
    logic s, d, p_scl, p_sda;
    bit in_xfer;
    int stretch_cnt;
    logic [7:0] shreg;
    p_scl = 1'b1; p_sda = 1'b1; in_xfer = 1'b0; stretch_cnt = 0; shreg = '0;
    forever begin
      @(negedge clk);
      s = scl_bus;
      d = sda_bus;
      if (s != p_scl || d != p_sda) n_edges++;
      if (stretch_cnt > 0) begin
        stretch_cnt--;
        if (stretch_cnt == 0) sl_scl_low = 1'b0;
      end
      if (p_scl && s && p_sda && !d) begin
        n_start++;
        if (gap_chk_en && have_stop) chk("bus_free_ge_quarter", int'(cyc - last_stop >= D), 1);
        in_xfer = 1'b1; sl_bitn = 0; sl_byten = 0; sl_sda_low = 1'b0;
      end else if (p_scl && s && !p_sda && d) begin
        n_stop++; in_xfer = 1'b0; last_stop = cyc; have_stop = 1'b1;
      end else if (!p_scl && s && in_xfer) begin
        if (sl_bitn < 8) begin
          shreg = {shreg[6:0], d};
          sl_bitn++;
          if (sl_bitn == 8) begin
            s_bytes.push_back(int'(shreg));
            sl_byten++;
          end
        end else begin
          sl_bitn++;
        end
      end else if (p_scl && !s && in_xfer) begin
        if (sl_bitn == 8) begin
          sl_sda_low = slave_en;
        end else if (sl_bitn == 9) begin
          sl_sda_low = 1'b0;
          sl_bitn = 0;
          if (stretch_en && sl_byten == 2) begin
            // Low phase extended 50 cycles beyond the master's own two low quarters.
            sl_scl_low = 1'b1;
            stretch_cnt = 2 * D + 50;
          end
        end
      end
      p_scl = s;
      p_sda = d;
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  int m_bytes[$];
  int m_stretch = 0;

  initial begin
    bit m_busy, m_err, exp_r;
    int m_rdy, k, lat;
    m_busy = 1'b0; m_err = 1'b0; m_rdy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0;
        chk("ready_in_reset", int'(ready), 0);
        chk("ack_err_in_reset", int'(ack_err), 0);
      end else begin
        exp_r = m_busy && (cyc == m_rdy);
        chk("ready", int'(ready), int'(exp_r));
        chk("ack_err", int'(ack_err), exp_r ? int'(m_err) : 0);
        if (exp_r) begin
          m_busy = 1'b0;
        end else if (!m_busy && valid) begin
          // Bytes on the wire: all three if acknowledged, else only the device byte.
          k = slave_en ? 3 : 1;
          lat = (2 + 36 * k + 4) * D + 1 + (slave_en ? m_stretch : 0);
          m_busy = 1'b1;
          m_err = !slave_en;
          m_rdy = cyc + lat;
          m_bytes.push_back(int'(device));
          if (slave_en) begin
            m_bytes.push_back(int'(addr));
            m_bytes.push_back(int'(data));
          end
        end
      end
    end
  end

  task automatic cmp_bytes(input string name);
    chk({name, "_nbytes"}, s_bytes.size(), m_bytes.size());
    for (int i = 0; i < m_bytes.size() && i < s_bytes.size(); i++)
      chk({name, "_byte"}, s_bytes[i], m_bytes[i]);
  endtask

  task automatic clear_logs();
    s_bytes.delete();
    m_bytes.delete();
  endtask

  task automatic run_one(input logic [7:0] dv, input logic [7:0] ad, input logic [7:0] dt,
                         output int lat, output int err);
    int acc;
    @(posedge clk); #1;
    device = dv; addr = ad; data = dt; valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    valid = 1'b0; device = 8'hff; addr = ~ad; data = ~dt;
    lat = -1; err = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = cyc + 1 - acc;
        err = int'(ack_err);
        break;
      end
    end
  endtask

  logic [7:0] tbl_a [10];
  logic [7:0] tbl_d [10];

  initial begin
    int lat, err, st0, sp0, idx, n_rdy;
    bit rdy_seen;
    tbl_a = '{8'h41, 8'h98, 8'h9a, 8'h9c, 8'h9d, 8'ha2, 8'ha3, 8'he0, 8'hf9, 8'h15};
    tbl_d = '{8'h10, 8'h03, 8'he0, 8'h30, 8'h61, 8'ha4, 8'ha4, 8'hd0, 8'h00, 8'h01};

    // 1: reset held with valid asserted
    rst_n = 1'b0; valid = 1'b1; device = 8'h72; addr = 8'h98; data = 8'h03;
    repeat (1000) @(negedge clk);
    chk("reset_scl_released", int'(scl_bus), 1);
    chk("reset_sda_released", int'(sda_bus), 1);
    chk("reset_no_bus_edges", n_edges, 0);
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 2: ACKed write 72/98/03
    clear_logs(); st0 = n_start; sp0 = n_stop;
    run_one(8'h72, 8'h98, 8'h03, lat, err);
    chk("s2_latency", lat, 457);
    chk("s2_ack_err", err, 0);
    chk("s2_dev", s_bytes[0], 'h72);
    chk("s2_addr", s_bytes[1], 'h98);
    chk("s2_data", s_bytes[2], 'h03);
    chk("s2_starts", n_start - st0, 1);
    chk("s2_stops", n_stop - sp0, 1);
    cmp_bytes("s2");
    repeat (10) @(posedge clk);

    // 3: no slave present
    clear_logs(); slave_en = 1'b0; sp0 = n_stop;
    run_one(8'h72, 8'h98, 8'h03, lat, err);
    chk("s3_latency", lat, 169);
    chk("s3_ack_err", err, 1);
    chk("s3_stop_issued", n_stop - sp0, 1);
    cmp_bytes("s3");
    slave_en = 1'b1;
    repeat (10) @(posedge clk);

    // 4: sequencer-style back-to-back table
    clear_logs(); gap_chk_en = 1'b1; idx = 0; n_rdy = 0; rdy_seen = 1'b0;
    for (int c = 0; c < 8000 && idx < 10; c++) begin
      @(posedge clk); #1;
      if (rdy_seen) idx++;
      valid = (idx < 10);
      device = 8'h72;
      if (idx < 10) begin
        addr = tbl_a[idx];
        data = tbl_d[idx];
      end
      @(negedge clk);
      rdy_seen = ready;
      if (ready) n_rdy++;
    end
    valid = 1'b0;
    chk("s4_all_done", idx, 10);
    chk("s4_ready_pulses", n_rdy, 10);
    for (int i = 0; i < 10; i++) begin
      chk("s4_addr", s_bytes[3 * i + 1], int'(tbl_a[i]));
      chk("s4_data", s_bytes[3 * i + 2], int'(tbl_d[i]));
    end
    cmp_bytes("s4");
    gap_chk_en = 1'b0;
    repeat (10) @(posedge clk);

    // 5: slave stretches SCL after byte 2
    clear_logs(); stretch_en = 1'b1; m_stretch = 50;
    run_one(8'h72, 8'h98, 8'h03, lat, err);
    chk("s5_latency", lat, 507);
    chk("s5_ack_err", err, 0);
    cmp_bytes("s5");
    stretch_en = 1'b0; m_stretch = 0;
    repeat (10) @(posedge clk);

    // 6: reset in the middle of byte 2
    clear_logs();
    @(posedge clk); #1;
    device = 8'h72; addr = 8'h98; data = 8'h03; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sl_byten == 1 && sl_bitn == 3) begin
        lat = 1;
        break;
      end
    end
    chk("s6_reached_byte2", lat, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("s6_async_scl_release", int'(scl_bus), 1);
    chk("s6_async_sda_release", int'(sda_bus), 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_rdy = 0;
    repeat (600) begin
      @(negedge clk);
      if (ready) n_rdy++;
    end
    chk("s6_no_ready_after_abort", n_rdy, 0);
    clear_logs();
    run_one(8'h72, 8'h98, 8'h03, lat, err);
    chk("s6_latency", lat, 457);
    chk("s6_ack_err", err, 0);
    cmp_bytes("s6");
    repeat (10) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-master, write-only I2C controller that takes one {device, addr, data} register write per handshake from the HDMI-transmitter configuration sequencer in display.
- Executes START, device byte, register-address byte, data byte, STOP on open-drain SCL/SDA, then pulses ready for one cycle.
- The sequencer advances its command index on that pulse and presents the next operands on the following cycle.
- Supports slave clock stretching; reports NACK.

Parameters:
- CLK_DIV, 250, clk cycles per SCL quarter-period (100 kHz SCL at 100 MHz clk); must be >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset; 0 forces idle and releases the bus immediately
- scl  inout  2-level  open-drain I2C clock; driven 0 or released to 'z', external pull-up
- sda  inout  2-level  open-drain I2C data; driven 0 or released to 'z'
- valid  input  1  request present; operands valid while high
- ready  output  1  one-cycle pulse: transaction finished (ACKed or NACKed)
- device  input  8  8-bit write address byte, R/W bit included (e.g. 8'h72); sent verbatim
- addr  input  8  register address byte
- data  input  8  register data byte
- ack_err  output  1  pulses with ready when any of the three bytes was NACKed

Behaviour:
- Reset (reset==0, async): state IDLE, scl/sda released, ready=0, ack_err=0, quarter counter=0, shift register=0.
- Bus inputs: scl/sda read through 2-flop synchronizers; all sampling uses the synchronized values.
- Quarter timer: counts 0..CLK_DIV-1; one tick per wrap. While SCL is released but synced SCL reads 0 (stretch), the count holds and no tick is issued.
- IDLE: if valid, latch {device, addr, data} into a 24-bit shift register and go to START on the next edge. Operand or valid changes after acceptance are ignored until ready.
- START, 2 quarters:
  - Q0: SDA low, SCL released.
  - Q1: SCL low.
- BIT, 4 quarters per bit, MSB first:
  - Q0: SCL low; SDA drives the bit (0 = drive low, 1 = release).
  - Q1: hold.
  - Q2: release SCL (stretch point).
  - Q3: SCL high.
- ACK, same 4 quarters with SDA released. Synced SDA is sampled on the tick ending Q2; 1 = NACK.
- Sequencing: after each ACK slot, NACK goes to STOP with the error flag set. Otherwise the next byte is sent, or STOP after the third byte.
- STOP, 4 quarters:
  - Q0: SCL low, SDA low.
  - Q1: SCL released.
  - Q2: SDA released.
  - Q3: bus-free hold, both released.
- DONE, 1 cycle: ready=1; ack_err=error flag; clear flag; go to IDLE.
  - No acceptance occurs in the DONE cycle. The first possible acceptance is in the IDLE cycle after, which sees operands the sequencer updated on the ready edge.
- Latency, acceptance edge to ready, no stretching:
  - ACKed transaction: (2+108+4)*CLK_DIV + 1 cycles.
  - NACK on byte k: (2+36k+4)*CLK_DIV + 1 cycles.
- Stretching adds exactly the held cycles.
- Counters: quarter counter width $clog2(CLK_DIV); bit counter 0..8 (bit 8 = ACK); byte counter 0..2. No wrap is reachable beyond these bounds.
- No arbitration or repeated START; reads are unsupported.
- Reset mid-transaction: bus released the same instant, no ready pulse, next valid begins a clean START.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE, START, BIT, ACK, STOP, DONE);
  - quarter-count constants (START_Q=2, BIT_Q=4, STOP_Q=4);
  - BYTES=3.
- Sub-module i2c_qtimer: quarter-tick generator with stretch hold and the SCL synchronizer. Inputs clk, reset, scl_released, scl_sync_in; outputs tick and quarter index.

Test Plan:
1. Reset held low with valid=1 -> scl/sda 'z', ready=0, ack_err=0; no bus edges for 1000 cycles.
2. CLK_DIV=4, ACKing slave model, device 8'h72, addr 8'h98, data 8'h03 -> slave decodes bytes 72,98,03 MSB first; START/STOP legal; ready single pulse 457 cycles after acceptance; ack_err=0.
3. No slave (pull-ups only), device 8'h72 -> NACK after the first byte; STOP issued; ready and ack_err pulse together 169 cycles after acceptance.
4. Sequencer-style driver: valid=(idx<10), operands from idx, idx+=ready; 10 table entries -> exactly 10 ready pulses; slave log matches all 10 {addr,data} pairs; >= 1 quarter bus-free between each STOP and the next START.
5. Slave stretches SCL low 50 cycles after the 9th clock of byte 2 -> bytes correct; ready delayed by exactly 50 cycles vs scenario 2.
6. Reset asserted mid-byte 2 for 3 cycles -> scl/sda released asynchronously; no ready pulse; the next accepted request produces a full correct transaction.
